// File: rtl/inst_fetch_if.sv
// SRAM read bus between the instruction-fetch stage (master) and the shared base SRAM (slave).
// Control outputs are active-low; read data is returned combinationally by the SRAM.
interface inst_fetch_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] sram_addr_o;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic [31:0]       sram_data_i;

    modport master (
        output sram_addr_o,
        output sram_ce_n_o,
        output sram_oe_n_o,
        input  sram_data_i
    );

    modport slave (
        input  sram_addr_o,
        input  sram_ce_n_o,
        input  sram_oe_n_o,
        output sram_data_i
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: reads one word per PC from the shared SRAM, buffers it for IF/ID,
// yields to the memory stage and drops in-flight fetches on branch redirect.
module inst_fetch #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic        mem_busy_i,
    inst_fetch_if.master sram,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    logic              retry_reg, retry_next;
    logic [31:0]       inst_reg, inst_next;
    logic [31:0]       inst_pc_reg, inst_pc_next;
    logic              valid_reg, valid_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              en_n_reg, en_n_next;
    logic              start_fetch;
    logic [31:0]       start_pc;

    // Only stall[1] (IF/ID) matters to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            fetch_pc_reg <= '0;
            retry_reg    <= 1'b0;
            inst_reg     <= '0;
            inst_pc_reg  <= '0;
            valid_reg    <= 1'b0;
            addr_reg     <= '0;
            en_n_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            fetch_pc_reg <= fetch_pc_next;
            retry_reg    <= retry_next;
            inst_reg     <= inst_next;
            inst_pc_reg  <= inst_pc_next;
            valid_reg    <= valid_next;
            addr_reg     <= addr_next;
            en_n_reg     <= en_n_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        fetch_pc_next = fetch_pc_reg;
        retry_next    = retry_reg;
        inst_next     = inst_reg;
        inst_pc_next  = inst_pc_reg;
        valid_next    = valid_reg;
        addr_next     = addr_reg;
        en_n_next     = en_n_reg;
        start_fetch   = 1'b0;
        // A fetch aborted by the memory stage is retried from its own PC, not a fresh pc_i.
        start_pc      = retry_reg ? fetch_pc_reg : pc_i;

        if (!ce_i) begin
            state_next = IDLE;
            valid_next = 1'b0;
            en_n_next  = 1'b1;
            retry_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (branch_flag_i) begin
                        retry_next = 1'b0;
                    end else if (!mem_busy_i) begin
                        start_fetch = 1'b1;
                    end
                end
                READ: begin
                    if (branch_flag_i) begin
                        state_next = IDLE;
                        en_n_next  = 1'b1;
                        retry_next = 1'b0;
                    end else if (mem_busy_i) begin
                        state_next = IDLE;
                        en_n_next  = 1'b1;
                        retry_next = 1'b1;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next   = HOLD;
                        inst_next    = sram.sram_data_i;
                        inst_pc_next = fetch_pc_reg;
                        valid_next   = 1'b1;
                        en_n_next    = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_flag_i) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end else if (!stall[1]) begin
                        valid_next = 1'b0;
                        if (!mem_busy_i) begin
                            start_fetch = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    en_n_next  = 1'b1;
                end
            endcase
        end

        if (start_fetch) begin
            state_next    = READ;
            cnt_next      = '0;
            fetch_pc_next = start_pc;
            addr_next     = start_pc[ADDR_W+1:2];
            en_n_next     = 1'b0;
            retry_next    = 1'b0;
        end
    end

    assign sram.sram_addr_o = addr_reg;
    assign sram.sram_ce_n_o = en_n_reg;
    assign sram.sram_oe_n_o = en_n_reg;
    assign inst_o           = inst_reg;
    assign inst_pc_o        = inst_pc_reg;
    assign inst_valid_o     = valid_reg;
    assign stallreq_o       = ce_i & ~rst & (state_reg != HOLD);
endmodule
